cmp_lookahead_pipe: RTL and testbench

- Parametrised, pipelined magnitude comparator built from 4-bit CMP lookahead blocks arranged in a log4 tree.
- Supports operand widths other than 16 bits and three compare modes: unsigned, signed two's-complement, and absolute value of signed.
- Has a valid/ready handshake with backpressure and a pass-through tag.
- Sits in the perceptron datapath after the weighted-sum stage; the tag returns a neuron/sample index alongside each result.

---
 rtl/cmp_lookahead_pipe.sv | 132 +++++++++++++
 tb/tb_cmp_lookahead_pipe.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_lookahead_pipe.sv
// Pipelined magnitude comparator: 4-bit CMP lookahead blocks in a log4 tree,
// one register stage per tree level, global-stall valid/ready handshake.
module cmp_lookahead_pipe #(
    parameter int D_WIDTH   = 16,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [D_WIDTH-1:0]   in_a,
    input  logic [D_WIDTH-1:0]   in_b,
    input  logic [1:0]           in_mode,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2:0]           out_result,
    output logic [TAG_WIDTH-1:0] out_tag
);

    localparam int IW     = D_WIDTH + 1;
    localparam int LEVELS = (IW <= 4) ? 1 : (IW <= 16) ? 2 : (IW <= 64) ? 3 : 4;
    localparam int PW     = 4 ** LEVELS;
    localparam int UW     = (PW - 1) / 3;

    // Bit offset of tree level lvl (1..LEVELS) inside the flat level vectors.
    function automatic int level_offset(input int lvl);
        int ofs;
        ofs = 0;
        for (int k = 1; k < lvl; k++) ofs += PW >> (2 * k);
        return ofs;
    endfunction

    function automatic logic [IW-1:0] prep(input logic [D_WIDTH-1:0] v, input logic [1:0] mode);
        logic [IW-1:0] ext;
        logic [IW-1:0] res;
        ext = {v[D_WIDTH-1], v};
        case (mode)
            2'b01:   res = {~v[D_WIDTH-1], v};
            2'b10:   res = ext[IW-1] ? (~ext + IW'(1)) : ext;
            default: res = {1'b0, v};
        endcase
        return res;
    endfunction

    logic [PW-1:0]        a_pad, b_pad;
    logic [PW-1:0]        p0_next, g0_next, s0_next;
    logic [PW-1:0]        p0_reg, g0_reg, s0_reg;
    logic [UW-1:0]        gu_next, su_next;
    logic [UW-1:0]        gu_reg, su_reg;
    logic                 eq_next, eq_reg;
    logic [LEVELS:0]      valid_reg;
    logic [TAG_WIDTH-1:0] tag_reg [0:LEVELS];
    logic                 stall;

    assign stall    = valid_reg[LEVELS] & ~out_ready;
    assign in_ready = ~stall;

    always_comb begin
        a_pad   = PW'(prep(in_a, in_mode));
        b_pad   = PW'(prep(in_b, in_mode));
        p0_next = a_pad ^ b_pad;
        g0_next = a_pad & ~b_pad;
        s0_next = ~a_pad & b_pad;
    end

    genvar gi, gj;
    generate
        for (gi = 1; gi <= LEVELS; gi++) begin : g_level
            localparam int NB      = PW >> (2 * gi);
            localparam int OUT_OFS = level_offset(gi);
            logic [4*NB-1:0] p_in, g_in, s_in;

            if (gi == 1) begin : g_src_bits
                assign p_in = p0_reg;
                assign g_in = g0_reg;
                assign s_in = s0_reg;
            end else begin : g_src_level
                localparam int IN_OFS = level_offset(gi - 1);
                assign g_in = gu_reg[IN_OFS +: 4*NB];
                assign s_in = su_reg[IN_OFS +: 4*NB];
                assign p_in = g_in ^ s_in;
            end

            for (gj = 0; gj < NB; gj++) begin : g_blk
                logic [3:0] p;
                logic [3:0] cmp;
                assign p   = p_in[4*gj +: 4];
                // One-hot select of the most significant differing bit.
                assign cmp = {p[3], p[2] & ~p[3], p[1] & ~(|p[3:2]), p[0] & ~(|p[3:1])};
                // Level data only moves when a valid transaction occupies the source stage.
                assign gu_next[OUT_OFS+gj] = valid_reg[gi-1] ? |(cmp & g_in[4*gj +: 4]) : gu_reg[OUT_OFS+gj];
                assign su_next[OUT_OFS+gj] = valid_reg[gi-1] ? |(cmp & s_in[4*gj +: 4]) : su_reg[OUT_OFS+gj];
                if (gi == LEVELS) begin : g_root
                    assign eq_next = valid_reg[gi-1] ? ~(|cmp) : eq_reg;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
            p0_reg    <= '0;
            g0_reg    <= '0;
            s0_reg    <= '0;
            gu_reg    <= '0;
            su_reg    <= '0;
            eq_reg    <= 1'b1;
            for (int k = 0; k <= LEVELS; k++) tag_reg[k] <= '0;
        end else if (!stall) begin
            valid_reg <= {valid_reg[LEVELS-1:0], in_valid};
            if (in_valid) begin
                p0_reg     <= p0_next;
                g0_reg     <= g0_next;
                s0_reg     <= s0_next;
                tag_reg[0] <= in_tag;
            end
            gu_reg <= gu_next;
            su_reg <= su_next;
            eq_reg <= eq_next;
            for (int k = 1; k <= LEVELS; k++) begin
                if (valid_reg[k-1]) tag_reg[k] <= tag_reg[k-1];
            end
        end
    end

    assign out_valid  = valid_reg[LEVELS];
    assign out_result = {eq_reg, gu_reg[UW-1], su_reg[UW-1]};
    assign out_tag    = tag_reg[LEVELS];

endmodule

// File: tb/tb_cmp_lookahead_pipe.sv
// Scoreboard bench for cmp_lookahead_pipe at D_WIDTH 16, 5 and 64: drivers push
// expected results, a negedge monitor compares every presented output.
module tb_cmp_lookahead_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        d16_in_valid, d16_in_ready, d16_out_valid, d16_out_ready;
    logic [15:0] d16_in_a, d16_in_b;
    logic [1:0]  d16_in_mode;
    logic [3:0]  d16_in_tag, d16_out_tag;
    logic [2:0]  d16_out_result;

    logic        d5_in_valid, d5_in_ready, d5_out_valid, d5_out_ready;
    logic [4:0]  d5_in_a, d5_in_b;
    logic [1:0]  d5_in_mode;
    logic [3:0]  d5_in_tag, d5_out_tag;
    logic [2:0]  d5_out_result;

    logic        d64_in_valid, d64_in_ready, d64_out_valid, d64_out_ready;
    logic [63:0] d64_in_a, d64_in_b;
    logic [1:0]  d64_in_mode;
    logic [3:0]  d64_in_tag, d64_out_tag;
    logic [2:0]  d64_out_result;

    cmp_lookahead_pipe #(.D_WIDTH(16), .TAG_WIDTH(4)) u_d16 (
        .clk(clk), .rst(rst), .in_valid(d16_in_valid), .in_ready(d16_in_ready),
        .in_a(d16_in_a), .in_b(d16_in_b), .in_mode(d16_in_mode), .in_tag(d16_in_tag),
        .out_valid(d16_out_valid), .out_ready(d16_out_ready),
        .out_result(d16_out_result), .out_tag(d16_out_tag));

    cmp_lookahead_pipe #(.D_WIDTH(5), .TAG_WIDTH(4)) u_d5 (
        .clk(clk), .rst(rst), .in_valid(d5_in_valid), .in_ready(d5_in_ready),
        .in_a(d5_in_a), .in_b(d5_in_b), .in_mode(d5_in_mode), .in_tag(d5_in_tag),
        .out_valid(d5_out_valid), .out_ready(d5_out_ready),
        .out_result(d5_out_result), .out_tag(d5_out_tag));

    cmp_lookahead_pipe #(.D_WIDTH(64), .TAG_WIDTH(4)) u_d64 (
        .clk(clk), .rst(rst), .in_valid(d64_in_valid), .in_ready(d64_in_ready),
        .in_a(d64_in_a), .in_b(d64_in_b), .in_mode(d64_in_mode), .in_tag(d64_in_tag),
        .out_valid(d64_out_valid), .out_ready(d64_out_ready),
        .out_result(d64_out_result), .out_tag(d64_out_tag));

    typedef struct {
        logic [2:0] res;
        logic [3:0] tag;
        int         acc;
        bit         chk;
    } exp_t;

    exp_t q16[$];
    exp_t q5[$];
    exp_t q64[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   rnd_on;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [2:0] model16(input logic [15:0] a, input logic [15:0] b, input logic [1:0] mode);
        int va, vb;
        case (mode)
            2'b01: begin
                va = int'($signed(a));
                vb = int'($signed(b));
            end
            2'b10: begin
                va = int'($signed(a));
                vb = int'($signed(b));
                if (va < 0) va = -va;
                if (vb < 0) vb = -vb;
            end
            default: begin
                va = int'({16'd0, a});
                vb = int'({16'd0, b});
            end
        endcase
        if (va == vb) return 3'b100;
        if (va > vb) return 3'b010;
        return 3'b001;
    endfunction

    // Called at a negedge; presents the pair, waits for in_ready, pushes the expectation.
    task automatic send(input int sel, input logic [63:0] a, input logic [63:0] b, input logic [1:0] mode,
                        input logic [3:0] tag, input logic [2:0] res, input bit chk);
        exp_t e;
        int   n;
        bit   rdy;
        e.res = res;
        e.tag = tag;
        e.chk = chk;
        case (sel)
            0: begin d16_in_valid = 1'b1; d16_in_a = a[15:0]; d16_in_b = b[15:0]; d16_in_mode = mode; d16_in_tag = tag; end
            1: begin d5_in_valid = 1'b1; d5_in_a = a[4:0]; d5_in_b = b[4:0]; d5_in_mode = mode; d5_in_tag = tag; end
            default: begin d64_in_valid = 1'b1; d64_in_a = a; d64_in_b = b; d64_in_mode = mode; d64_in_tag = tag; end
        endcase
        n = 0;
        #1;
        forever begin
            rdy = (sel == 0) ? d16_in_ready : (sel == 1) ? d5_in_ready : d64_in_ready;
            if (rdy || n >= 100) break;
            n++;
            @(negedge clk);
            #1;
        end
        if (!rdy) begin
            tests++;
            fails++;
            $display("FAIL send_timeout s%0d tag %0d: in_ready stayed 0, expected 1", sel, tag);
        end else begin
            e.acc = cyc;
            case (sel)
                0: q16.push_back(e);
                1: q5.push_back(e);
                default: q64.push_back(e);
            endcase
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        d16_in_valid = 1'b0;
        d5_in_valid  = 1'b0;
        d64_in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input int sel);
        int n;
        int sz;
        n = 0;
        forever begin
            sz = (sel == 0) ? q16.size() : (sel == 1) ? q5.size() : q64.size();
            if (sz == 0 || n >= 100) break;
            n++;
            @(negedge clk);
        end
        check($sformatf("drain_s%0d_pending", sel), 64'(sz), 64'(0));
    endtask

    task automatic mon(input int sel);
        logic       v, r, ir;
        logic [2:0] res;
        logic [3:0] tag;
        exp_t       e;
        int         lat, qn;
        case (sel)
            0: begin v = d16_out_valid; r = d16_out_ready; ir = d16_in_ready; res = d16_out_result; tag = d16_out_tag; lat = 4; qn = q16.size(); end
            1: begin v = d5_out_valid; r = d5_out_ready; ir = d5_in_ready; res = d5_out_result; tag = d5_out_tag; lat = 3; qn = q5.size(); end
            default: begin v = d64_out_valid; r = d64_out_ready; ir = d64_in_ready; res = d64_out_result; tag = d64_out_tag; lat = 5; qn = q64.size(); end
        endcase
        check($sformatf("in_ready_s%0d", sel), 64'(ir), 64'(!(v && !r)));
        if (v) begin
            if (qn == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_s%0d: out_valid=1 tag %0d result %b, expected no result", sel, tag, res);
            end else begin
                case (sel)
                    0: e = q16[0];
                    1: e = q5[0];
                    default: e = q64[0];
                endcase
                check($sformatf("result_s%0d_tag%0d", sel, e.tag), 64'(res), 64'(e.res));
                check($sformatf("tag_s%0d", sel), 64'(tag), 64'(e.tag));
                if (r) begin
                    case (sel)
                        0: void'(q16.pop_front());
                        1: void'(q5.pop_front());
                        default: void'(q64.pop_front());
                    endcase
                    if (e.chk) check($sformatf("latency_s%0d_tag%0d", sel, e.tag), 64'(cyc - e.acc), 64'(lat));
                    $display("[TB] s%0d tag %0d result %b", sel, tag, res);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        #2;
        mon(0);
        mon(1);
        mon(2);
    end

    logic [15:0] p1_a [8] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h8000, 16'h8000, 16'hFFFF};
    logic [15:0] p1_b [8] = '{16'h0001, 16'h0001, 16'h0001, 16'h0002, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h0001};
    logic [1:0]  p1_m [8] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd3};
    logic [2:0]  p1_r [8] = '{3'b010, 3'b001, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010};

    logic [15:0] st_a [8] = '{16'h0000, 16'h1234, 16'h8000, 16'h8000, 16'hFFF0, 16'h7FFF, 16'h0100, 16'hFFFE};
    logic [15:0] st_b [8] = '{16'h0000, 16'h1235, 16'h0001, 16'h0001, 16'h0010, 16'h8001, 16'h00FF, 16'hFFFF};
    logic [1:0]  st_m [8] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd2, 2'd1, 2'd1};
    logic [2:0]  st_r [8] = '{3'b100, 3'b001, 3'b001, 3'b010, 3'b100, 3'b100, 3'b010, 3'b001};

    logic [4:0]  s5_a [6] = '{5'h15, 5'h10, 5'h10, 5'h00, 5'h10, 5'h10};
    logic [4:0]  s5_b [6] = '{5'h15, 5'h00, 5'h00, 5'h01, 5'h00, 5'h0F};
    logic [1:0]  s5_m [6] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd3, 2'd2};
    logic [2:0]  s5_r [6] = '{3'b100, 3'b010, 3'b001, 3'b001, 3'b010, 3'b010};

    logic [63:0] s64_a [7] = '{64'hDEADBEEF01234567, 64'h8000000000000000, 64'h8000000000000000, 64'h0,
                               64'h8000000000000000, 64'h8000000000000000, 64'h0};
    logic [63:0] s64_b [7] = '{64'hDEADBEEF01234567, 64'h0, 64'h0, 64'h1, 64'h0, 64'h7FFFFFFFFFFFFFFF, 64'h1};
    logic [1:0]  s64_m [7] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1};
    logic [2:0]  s64_r [7] = '{3'b100, 3'b010, 3'b001, 3'b001, 3'b010, 3'b010, 3'b001};

    initial begin
        rst = 1'b1;
        d16_in_valid = 1'b0; d16_in_a = '0; d16_in_b = '0; d16_in_mode = '0; d16_in_tag = '0; d16_out_ready = 1'b1;
        d5_in_valid = 1'b0;  d5_in_a = '0;  d5_in_b = '0;  d5_in_mode = '0;  d5_in_tag = '0;  d5_out_ready = 1'b1;
        d64_in_valid = 1'b0; d64_in_a = '0; d64_in_b = '0; d64_in_mode = '0; d64_in_tag = '0; d64_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_out_valid", 64'(d16_out_valid), 64'(0));
        check("reset_out_result", 64'(d16_out_result), 64'(3'b100));
        check("reset_out_tag", 64'(d16_out_tag), 64'(0));
        check("reset_in_ready", 64'(d16_in_ready), 64'(1));
        check("reset_d64_out_result", 64'(d64_out_result), 64'(3'b100));
        rst = 1'b0;

        for (int i = 0; i < 8; i++) send(0, 64'(p1_a[i]), 64'(p1_b[i]), p1_m[i], 4'(i + 1), p1_r[i], 1'b1);
        idle(1);
        drain(0);

        fork
            for (int i = 0; i < 8; i++) send(0, 64'(st_a[i]), 64'(st_b[i]), st_m[i], 4'(i), st_r[i], 1'b0);
            begin
                int n;
                n = 0;
                while (!d16_out_valid && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                check("stall_first_tag", 64'(d16_out_tag), 64'(0));
                d16_out_ready = 1'b0;
                repeat (5) begin
                    #1;
                    check("stall_in_ready", 64'(d16_in_ready), 64'(0));
                    @(negedge clk);
                end
                d16_out_ready = 1'b1;
            end
        join
        idle(1);
        drain(0);

        rnd_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    logic [15:0] ra, rb;
                    logic [1:0]  rm;
                    if ($urandom_range(0, 4) == 0) begin
                        d16_in_valid = 1'b0;
                        @(negedge clk);
                    end
                    ra = 16'($urandom);
                    rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
                    rm = 2'($urandom_range(0, 3));
                    send(0, 64'(ra), 64'(rb), rm, 4'(i), model16(ra, rb, rm), 1'b0);
                end
                d16_in_valid = 1'b0;
                rnd_on = 1'b0;
            end
            while (rnd_on) begin
                @(negedge clk);
                d16_out_ready = ($urandom_range(0, 3) != 0);
            end
        join
        @(negedge clk);
        d16_out_ready = 1'b1;
        drain(0);

        // Three pairs in flight, then a one-cycle reset; none of them may come back.
        send(0, 64'h0005, 64'h0003, 2'd0, 4'd9, 3'b010, 1'b1);
        send(0, 64'h0003, 64'h0005, 2'd0, 4'd10, 3'b001, 1'b1);
        send(0, 64'h0007, 64'h0007, 2'd0, 4'd11, 3'b100, 1'b1);
        d16_in_valid = 1'b0;
        rst = 1'b1;
        q16.delete();
        #1;
        check("rst_in_ready_during", 64'(d16_in_ready), 64'(1));
        @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid_after", 64'(d16_out_valid), 64'(0));
        check("rst_out_result_after", 64'(d16_out_result), 64'(3'b100));
        check("rst_out_tag_after", 64'(d16_out_tag), 64'(0));
        check("rst_in_ready_after", 64'(d16_in_ready), 64'(1));
        send(0, 64'h1000, 64'h0FFF, 2'd0, 4'd12, 3'b010, 1'b1);
        idle(8);
        drain(0);

        for (int i = 0; i < 6; i++) send(1, 64'(s5_a[i]), 64'(s5_b[i]), s5_m[i], 4'(i), s5_r[i], 1'b1);
        idle(1);
        drain(1);
        for (int i = 0; i < 7; i++) send(2, s64_a[i], s64_b[i], s64_m[i], 4'(i), s64_r[i], 1'b1);
        idle(1);
        drain(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
